mem_arbiter: RTL and testbench

- Shares the single data RAM (one combinational read port, one word-wide synchronous write port) between two requesters.
  - m0: core load/store unit.
  - m1: program loader / debug master.
- Provides round-robin arbitration, a valid/gnt/rvalid handshake per requester, and byte-enable stores.
- The RAM only accepts whole-word writes, so partial stores are sequenced as read-modify-write (RMW).

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Requester handshakes and RAM port bundle for mem_arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [3:0]    m0_be;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [3:0]    m1_be;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          ram_r_ena_o;
    logic [AW-1:0] ram_r_addr_o;
    logic          ram_w_ena_o;
    logic [AW-1:0] ram_w_addr_o;
    logic [DW-1:0] ram_w_data_o;
    logic [DW-1:0] ram_r_data_i;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        input  ram_r_data_i,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_r_ena_o, ram_r_addr_o, ram_w_ena_o, ram_w_addr_o, ram_w_data_o
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        output ram_r_data_i,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_r_ena_o, ram_r_addr_o, ram_w_ena_o, ram_w_addr_o, ram_w_data_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin sharing of one data RAM between two requesters, with
//            read-modify-write sequencing for partial-byte stores.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_100MHz,
    input  logic          arst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } state_t;

    // All-ones can never equal an aligned read address, so the RAM's
    // write-data forwarding stays inert while no write is in progress.
    localparam logic [AW-1:0] c_no_write_addr = {AW{1'b1}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rr_ptr;
    logic          r_rmw_idx;
    logic [AW-1:0] r_rmw_addr;
    logic [DW-1:0] r_rmw_old;
    logic [DW-1:0] r_rmw_new;
    logic [3:0]    r_rmw_be;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_idle;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_gnt_any;
    logic          w_sel;
    logic          w_we;
    logic [AW-1:0] w_addr_al;
    logic [DW-1:0] w_wdata;
    logic [3:0]    w_be;
    logic          w_full;
    logic          w_partial;
    logic [DW-1:0] w_merge;
    logic          w_unused_addr_lsbs;

    // Grants are gated by reset so every output sits at its reset value
    // while arst_n is low, independent of the requesters.
    assign w_idle    = (r_state == S_IDLE) && arst_n;
    assign w_gnt0    = w_idle && bus.m0_req && (!bus.m1_req || r_rr_ptr);
    assign w_gnt1    = w_idle && bus.m1_req && (!bus.m0_req || !r_rr_ptr);
    assign w_gnt_any = w_gnt0 || w_gnt1;
    assign w_sel     = w_gnt1;

    assign w_we      = w_sel ? bus.m1_we : bus.m0_we;
    assign w_addr_al = w_sel ? {bus.m1_addr[AW-1:2], 2'b00} : {bus.m0_addr[AW-1:2], 2'b00};
    assign w_wdata   = w_sel ? bus.m1_wdata : bus.m0_wdata;
    assign w_be      = w_sel ? bus.m1_be : bus.m0_be;
    assign w_full    = (w_be == 4'b1111);
    assign w_partial = w_we && !w_full && (w_be != 4'b0000);

    assign w_unused_addr_lsbs = ^{bus.m0_addr[1:0], bus.m1_addr[1:0]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign w_merge[8*gi +: 8] = r_rmw_be[gi] ? r_rmw_new[8*gi +: 8] : r_rmw_old[8*gi +: 8];
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        bus.ram_r_ena_o  = 1'b0;
        bus.ram_r_addr_o = '0;
        bus.ram_w_ena_o  = 1'b0;
        bus.ram_w_addr_o = c_no_write_addr;
        bus.ram_w_data_o = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_any) begin
                    if (!w_we || w_partial) begin
                        bus.ram_r_ena_o  = 1'b1;
                        bus.ram_r_addr_o = w_addr_al;
                    end else if (w_full) begin
                        bus.ram_w_ena_o  = 1'b1;
                        bus.ram_w_addr_o = w_addr_al;
                        bus.ram_w_data_o = w_wdata;
                    end
                    if (w_partial) begin
                        w_state_nxt = S_RMW;
                    end
                end
            end
            S_RMW: begin
                bus.ram_w_ena_o  = 1'b1;
                bus.ram_w_addr_o = r_rmw_addr;
                bus.ram_w_data_o = w_merge;
                w_state_nxt      = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            r_rr_ptr   <= 1'b1;
            r_rmw_idx  <= 1'b0;
            r_rmw_addr <= '0;
            r_rmw_old  <= '0;
            r_rmw_new  <= '0;
            r_rmw_be   <= 4'b0000;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (r_state == S_RMW) begin
                if (r_rmw_idx) begin
                    r_rvalid1 <= 1'b1;
                    r_rdata1  <= '0;
                end else begin
                    r_rvalid0 <= 1'b1;
                    r_rdata0  <= '0;
                end
            end else if (w_gnt_any) begin
                r_rr_ptr <= w_sel;
                if (w_partial) begin
                    r_rmw_idx  <= w_sel;
                    r_rmw_addr <= w_addr_al;
                    r_rmw_old  <= bus.ram_r_data_i;
                    r_rmw_new  <= w_wdata;
                    r_rmw_be   <= w_be;
                end else if (w_sel) begin
                    r_rvalid1 <= 1'b1;
                    r_rdata1  <= w_we ? '0 : bus.ram_r_data_i;
                end else begin
                    r_rvalid0 <= 1'b1;
                    r_rdata0  <= w_we ? '0 : bus.ram_r_data_i;
                end
            end
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = r_rvalid0;
    assign bus.m1_rvalid = r_rvalid1;
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed scenarios plus randomized traffic against a
//            transaction-level memory model for mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int N_RAND = 400;

    logic clk_100MHz = 1'b0;
    logic arst_n     = 1'b0;
    int   n_checks   = 0;
    int   n_pass     = 0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_100MHz (clk_100MHz),
        .arst_n     (arst_n),
        .bus        (bus)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // 64-word RAM: combinational read, write at the clock edge
    logic [31:0] ram [0:63] = '{default: 32'h0};
    assign bus.ram_r_data_i = ram[bus.ram_r_addr_o[7:2]];
    always @(posedge clk_100MHz) begin
        if (bus.ram_w_ena_o) ram[bus.ram_w_addr_o[7:2]] <= bus.ram_w_data_o;
    end

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_be = be;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_be = be;
    endtask

    task automatic idle_inputs();
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        idle_inputs();
        bus.m0_req = 1'b1;
        bus.m1_req = 1'b1;
        repeat (2) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid} !== 4'b0000) $display("FAIL rst_hs: got %b want 0000", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid}); else n_pass++;
        n_checks++; if ({bus.m0_rdata, bus.m1_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h want 0", {bus.m0_rdata, bus.m1_rdata}); else n_pass++;
        n_checks++; if ({bus.ram_r_ena_o, bus.ram_w_ena_o} !== 2'b00) $display("FAIL rst_ena: got %b want 00", {bus.ram_r_ena_o, bus.ram_w_ena_o}); else n_pass++;
        n_checks++; if ({bus.ram_r_addr_o, bus.ram_w_data_o} !== 64'h0) $display("FAIL rst_raddr_wdata: got %h want 0", {bus.ram_r_addr_o, bus.ram_w_data_o}); else n_pass++;
        n_checks++; if (bus.ram_w_addr_o !== 32'hFFFF_FFFF) $display("FAIL rst_waddr: got %h want ffffffff", bus.ram_w_addr_o); else n_pass++;
        idle_inputs();
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        drive_m0(1'b1, 1'b0, 32'h12, 32'h5555_5555, 4'hF);
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) $display("FAIL rd_gnt: got %b want 10", {bus.m0_gnt, bus.m1_gnt}); else n_pass++;
        n_checks++; if (bus.ram_r_ena_o !== 1'b1 || bus.ram_r_addr_o !== 32'h10) $display("FAIL rd_ram: got ena %b addr %h want 1 00000010", bus.ram_r_ena_o, bus.ram_r_addr_o); else n_pass++;
        n_checks++; if (bus.ram_w_addr_o !== 32'hFFFF_FFFF) $display("FAIL rd_waddr: got %h want ffffffff", bus.ram_w_addr_o); else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b10 || bus.m0_rdata !== 32'h0) $display("FAIL rd_resp: got rvalid %b rdata %h want 10 00000000", {bus.m0_rvalid, bus.m1_rvalid}, bus.m0_rdata); else n_pass++;
        tick();
        @(negedge clk_100MHz);
        n_checks++; if (bus.m0_rvalid !== 1'b0) $display("FAIL rd_pulse: got rvalid %b want 0", bus.m0_rvalid); else n_pass++;
        tick();
    endtask

    task automatic test_write_then_read();
        drive_m1(1'b1, 1'b1, 32'h22, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) $display("FAIL wr_gnt: got %b want 01", {bus.m0_gnt, bus.m1_gnt}); else n_pass++;
        n_checks++; if ({bus.ram_r_ena_o, bus.ram_w_ena_o} !== 2'b01 || bus.ram_w_addr_o !== 32'h20 || bus.ram_w_data_o !== 32'hDEAD_BEEF) $display("FAIL wr_ram: got ena %b addr %h data %h want 01 00000020 deadbeef", {bus.ram_r_ena_o, bus.ram_w_ena_o}, bus.ram_w_addr_o, bus.ram_w_data_o); else n_pass++;
        tick();
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) $display("FAIL raw_gnt: got %b want 10", {bus.m0_gnt, bus.m1_gnt}); else n_pass++;
        n_checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b01 || bus.m1_rdata !== 32'h0) $display("FAIL wr_resp: got rvalid %b rdata %h want 01 00000000", {bus.m0_rvalid, bus.m1_rvalid}, bus.m1_rdata); else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b10 || bus.m0_rdata !== 32'hDEAD_BEEF) $display("FAIL raw_resp: got rvalid %b rdata %h want 10 deadbeef", {bus.m0_rvalid, bus.m1_rvalid}, bus.m0_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_partial_rmw();
        drive_m1(1'b1, 1'b1, 32'h40, 32'h1122_3344, 4'hF);
        tick();
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m0(1'b1, 1'b1, 32'h43, 32'hAABB_CCDD, 4'b0101);
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) $display("FAIL rmw_gnt: got %b want 10", {bus.m0_gnt, bus.m1_gnt}); else n_pass++;
        n_checks++; if ({bus.ram_r_ena_o, bus.ram_w_ena_o} !== 2'b10 || bus.ram_r_addr_o !== 32'h40) $display("FAIL rmw_read: got ena %b addr %h want 10 00000040", {bus.ram_r_ena_o, bus.ram_w_ena_o}, bus.ram_r_addr_o); else n_pass++;
        tick();
        // m1 arrives while the merge write is in flight
        drive_m0(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h1234_5678, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) $display("FAIL rmw_hold_gnt: got %b want 00", {bus.m0_gnt, bus.m1_gnt}); else n_pass++;
        n_checks++; if (bus.ram_w_ena_o !== 1'b1 || bus.ram_w_addr_o !== 32'h40 || bus.ram_w_data_o !== 32'h11BB_33DD) $display("FAIL rmw_write: got ena %b addr %h data %h want 1 00000040 11bb33dd", bus.ram_w_ena_o, bus.ram_w_addr_o, bus.ram_w_data_o); else n_pass++;
        n_checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) $display("FAIL rmw_early_rvalid: got %b want 00", {bus.m0_rvalid, bus.m1_rvalid}); else n_pass++;
        tick();
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) $display("FAIL rmw_m1_gnt: got %b want 01", {bus.m0_gnt, bus.m1_gnt}); else n_pass++;
        n_checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b10 || bus.m0_rdata !== 32'h0) $display("FAIL rmw_resp: got rvalid %b rdata %h want 10 00000000", {bus.m0_rvalid, bus.m1_rvalid}, bus.m0_rdata); else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b01 || bus.m1_rdata !== 32'h11BB_33DD) $display("FAIL rmw_readback: got rvalid %b rdata %h want 01 11bb33dd", {bus.m0_rvalid, bus.m1_rvalid}, bus.m1_rdata); else n_pass++;
        tick();
        drive_m0(1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000);
        @(negedge clk_100MHz);
        n_checks++; if (bus.m0_gnt !== 1'b1 || {bus.ram_r_ena_o, bus.ram_w_ena_o} !== 2'b00) $display("FAIL be0_noaccess: got gnt %b ena %b want 1 00", bus.m0_gnt, {bus.ram_r_ena_o, bus.ram_w_ena_o}); else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk_100MHz);
        n_checks++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h0) $display("FAIL be0_resp: got rvalid %b rdata %h want 1 00000000", bus.m0_rvalid, bus.m0_rdata); else n_pass++;
        n_checks++; if (ram[16] !== 32'h11BB_33DD) $display("FAIL be0_ram: got %h want 11bb33dd", ram[16]); else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        int want = 1;
        int prev = 0;
        drive_m0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_100MHz);
            n_checks++; if ({bus.m0_gnt, bus.m1_gnt} !== (want == 1 ? 2'b01 : 2'b10)) $display("FAIL rr_gnt[%0d]: got %b want m%0d", k, {bus.m0_gnt, bus.m1_gnt}, want); else n_pass++;
            if (k > 0) begin
                n_checks++;
                if ({bus.m0_rvalid, bus.m1_rvalid} !== (prev == 1 ? 2'b01 : 2'b10) ||
                    (prev == 1 ? bus.m1_rdata !== 32'h11BB_33DD : bus.m0_rdata !== 32'hDEAD_BEEF))
                    $display("FAIL rr_resp[%0d]: got rvalid %b rdata0 %h rdata1 %h want m%0d", k, {bus.m0_rvalid, bus.m1_rvalid}, bus.m0_rdata, bus.m1_rdata, prev);
                else n_pass++;
            end
            prev = want;
            want = 1 - want;
            tick();
        end
        idle_inputs();
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b10) $display("FAIL rr_last: got %b want 10", {bus.m0_rvalid, bus.m1_rvalid}); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_rmw();
        drive_m0(1'b1, 1'b1, 32'h40, 32'h9988_7766, 4'b1000);
        @(negedge clk_100MHz);
        n_checks++; if (bus.m0_gnt !== 1'b1) $display("FAIL arst_gnt: got %b want 1", bus.m0_gnt); else n_pass++;
        tick();
        idle_inputs();
        drive_m1(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        #1 arst_n = 1'b0;
        #1;
        n_checks++; if ({bus.ram_w_ena_o, bus.m0_gnt, bus.m1_gnt} !== 3'b000 || bus.ram_w_addr_o !== 32'hFFFF_FFFF) $display("FAIL arst_outputs: got wena/gnt %b waddr %h want 000 ffffffff", {bus.ram_w_ena_o, bus.m0_gnt, bus.m1_gnt}, bus.ram_w_addr_o); else n_pass++;
        tick();
        n_checks++; if (ram[16] !== 32'h11BB_33DD) $display("FAIL arst_ram: got %h want 11bb33dd", ram[16]); else n_pass++;
        @(negedge clk_100MHz);
        idle_inputs();
        arst_n = 1'b1;
        tick();
        @(negedge clk_100MHz);
        n_checks++; if ({bus.m0_rvalid, bus.m1_rvalid, bus.ram_w_ena_o} !== 3'b000) $display("FAIL arst_no_resp: got %b want 000", {bus.m0_rvalid, bus.m1_rvalid, bus.ram_w_ena_o}); else n_pass++;
        tick();
        drive_m0(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        tick();
        idle_inputs();
        @(negedge clk_100MHz);
        n_checks++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h11BB_33DD) $display("FAIL arst_readback: got rvalid %b rdata %h want 1 11bb33dd", bus.m0_rvalid, bus.m0_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic        pend    [0:1];
        logic        p_we    [0:1];
        logic [31:0] p_addr  [0:1];
        logic [31:0] p_wdata [0:1];
        logic [3:0]  p_be    [0:1];
        logic [31:0] ref_mem [0:63];
        logic        exp_rv  [0:1][0:N_RAND+7];
        logic [31:0] exp_rd  [0:1][0:N_RAND+7];
        logic [31:0] merged;
        logic [5:0]  word;
        logic [1:0]  want_gnt;
        int          last;
        int          g;
        bit          busy;
        bit          busy_next;

        idle_inputs();
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            drive_m0(1'b1, 1'b1, 32'(i) << 2, ref_mem[i], 4'hF);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        last = 0;
        busy_next = 1'b0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0;
            for (int c = 0; c < N_RAND + 8; c++) exp_rv[m][c] = 1'b0;
        end

        for (int c = 0; c < N_RAND + 4; c++) begin
            busy = busy_next;
            busy_next = 1'b0;
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && c < N_RAND && $urandom_range(0, 2) != 0) begin
                    pend[m]    = 1'b1;
                    p_we[m]    = 1'($urandom_range(0, 1));
                    p_addr[m]  = $urandom;
                    p_wdata[m] = $urandom;
                    case ($urandom_range(0, 3))
                        0:       p_be[m] = 4'hF;
                        1:       p_be[m] = 4'h0;
                        default: p_be[m] = 4'($urandom_range(0, 15));
                    endcase
                end
            end
            // Fields are don't-care while req is low, so feed junk there
            drive_m0(pend[0], pend[0] ? p_we[0] : 1'($urandom), pend[0] ? p_addr[0] : $urandom,
                     pend[0] ? p_wdata[0] : $urandom, pend[0] ? p_be[0] : 4'($urandom));
            drive_m1(pend[1], pend[1] ? p_we[1] : 1'($urandom), pend[1] ? p_addr[1] : $urandom,
                     pend[1] ? p_wdata[1] : $urandom, pend[1] ? p_be[1] : 4'($urandom));

            g = -1;
            if (!busy) begin
                if (pend[0] && pend[1]) g = 1 - last;
                else if (pend[0])       g = 0;
                else if (pend[1])       g = 1;
            end
            want_gnt = (g == 0) ? 2'b10 : (g == 1) ? 2'b01 : 2'b00;

            @(negedge clk_100MHz);
            n_checks++; if ({bus.m0_gnt, bus.m1_gnt} !== want_gnt) $display("FAIL rand_gnt @%0d: got %b want %b", c, {bus.m0_gnt, bus.m1_gnt}, want_gnt); else n_pass++;
            n_checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== {exp_rv[0][c], exp_rv[1][c]}) $display("FAIL rand_rvalid @%0d: got %b want %b", c, {bus.m0_rvalid, bus.m1_rvalid}, {exp_rv[0][c], exp_rv[1][c]}); else n_pass++;
            if (exp_rv[0][c]) begin
                n_checks++; if (bus.m0_rdata !== exp_rd[0][c]) $display("FAIL rand_rdata0 @%0d: got %h want %h", c, bus.m0_rdata, exp_rd[0][c]); else n_pass++;
            end
            if (exp_rv[1][c]) begin
                n_checks++; if (bus.m1_rdata !== exp_rd[1][c]) $display("FAIL rand_rdata1 @%0d: got %h want %h", c, bus.m1_rdata, exp_rd[1][c]); else n_pass++;
            end
            if (!bus.ram_w_ena_o) begin
                n_checks++; if (bus.ram_w_addr_o !== 32'hFFFF_FFFF) $display("FAIL rand_waddr @%0d: got %h want ffffffff", c, bus.ram_w_addr_o); else n_pass++;
            end

            if (g >= 0) begin
                word = p_addr[g][7:2];
                if (!p_we[g]) begin
                    exp_rv[g][c+1] = 1'b1;
                    exp_rd[g][c+1] = ref_mem[word];
                end else begin
                    for (int b = 0; b < 4; b++)
                        merged[8*b +: 8] = p_be[g][b] ? p_wdata[g][8*b +: 8] : ref_mem[word][8*b +: 8];
                    ref_mem[word] = merged;
                    if (p_be[g] != 4'hF && p_be[g] != 4'h0) begin
                        exp_rv[g][c+2] = 1'b1;
                        exp_rd[g][c+2] = 32'h0;
                        busy_next = 1'b1;
                    end else begin
                        exp_rv[g][c+1] = 1'b1;
                        exp_rd[g][c+1] = 32'h0;
                    end
                end
                pend[g] = 1'b0;
                last = g;
            end
            tick();
        end
        idle_inputs();
        n_checks++; if (pend[0] || pend[1]) $display("FAIL rand_drain: got pending %b%b want 00", pend[0], pend[1]); else n_pass++;
        for (int i = 0; i < 64; i++) begin
            n_checks++; if (ram[i] !== ref_mem[i]) $display("FAIL rand_ram[%0d]: got %h want %h", i, ram[i], ref_mem[i]); else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_then_read();
        test_partial_rmw();
        test_round_robin();
        test_reset_mid_rmw();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
